serial_parity_frame_ctrl: RTL

- Sequences a serial parity check over framed words.
- Detects a start bit and counts WIDTH data bits, LSB first.
- Tracks running parity with an even/odd state bit, then checks the received parity bit and the stop bit.
- Presents the assembled word with status flags on a valid/ack handshake.
- Sits between the serial line sampler (which supplies bit strobes) and the word-level consumer.

---
 rtl/serial_parity_frame_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/serial_parity_frame_ctrl.sv
// ---------------------------------------------------------------------------
// serial_parity_frame_ctrl
//
// Receives framed serial words (start bit, WIDTH data bits LSB first, one
// parity bit, one stop bit), checks the parity and stop bits, and holds the
// assembled word with status flags for a valid/ack consumer.
//
// Parameters
//   WIDTH       data bits per frame (1..32)
//   ODD_PARITY  0 = even parity, 1 = odd parity
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   x           serial data bit, sampled only when bit_en=1
//   bit_en      one-cycle strobe per serial bit period
//   ack         consumer accepts the held word (ignored while valid=0)
//   data        assembled data word
//   valid       data and flags hold a completed frame
//   parity_err  received parity bit disagreed with the data
//   frame_err   stop bit was sampled as 0
//   overrun     a frame completed while the previous one was still pending
//   busy        receiver is inside a frame (not IDLE)
// ---------------------------------------------------------------------------
module serial_parity_frame_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             bit_en,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_par;       // running parity of data bits, 1 = odd
    logic             r_pe_pend;   // parity result waiting for the stop bit
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_pe;
    logic             r_fe;
    logic             r_ovr;
    logic             r_busy;

    logic w_shift_en;
    logic w_last_bit;
    logic w_complete;

    assign w_shift_en = bit_en && (r_state == S_DATA);
    assign w_last_bit = (r_cnt == CW'(WIDTH - 1));
    assign w_complete = bit_en && (r_state == S_STOP);

    // Each data bit lands at its own position, selected by the bit counter,
    // so no shifting of earlier bits is required.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shift[gi] <= 1'b0;
                end else if (w_shift_en && (r_cnt == CW'(gi))) begin
                    r_shift[gi] <= x;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_par     <= 1'b0;
            r_pe_pend <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_pe      <= 1'b0;
            r_fe      <= 1'b0;
            r_ovr     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // Frame sequencing, advanced only on bit strobes.
            if (bit_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (!x) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            r_par   <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_par <= r_par ^ x;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last_bit) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_pe_pend <= r_par ^ x ^ ODD_PARITY;
                        r_state   <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end

            // Output holding register and handshake. A completion that meets
            // an unacknowledged word drops the new frame and flags overrun;
            // an ack on the same edge frees the slot for the new frame.
            if (w_complete) begin
                if (!r_valid || ack) begin
                    r_data  <= r_shift;
                    r_pe    <= r_pe_pend;
                    r_fe    <= ~x;
                    r_valid <= 1'b1;
                    r_ovr   <= 1'b0;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && ack) begin
                r_valid <= 1'b0;
                r_pe    <= 1'b0;
                r_fe    <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_pe;
    assign frame_err  = r_fe;
    assign overrun    = r_ovr;
    assign busy       = r_busy;

endmodule
